// File: rtl/attn_seq_ctrl.sv
// -----------------------------------------------------------------------------
// attn_seq_ctrl
//   Instruction sequencer for the attention core. A single accepted start
//   produces the whole instruction stream: K-vector load, Q-vector execute,
//   output FIFO drain into psum memory and, when compiled in, the SFP
//   normalization pass with write-back.
//
//   Optional feature macro: ATTN_SEQ_SFP_NORM_EN
//     defined     : NRD/NACC/NDIV/NWB states exist, DRAIN exits to NRD.
//     not defined : those states are absent, DRAIN exits to DONE and
//                   inst[20:17] are constant 0.
//
// Parameters
//   COL      : number of K vectors loaded (array columns)
//   ROWS_MAX : maximum number of Q rows (qmem/pmem depth)
//   TIMEOUT  : idle DRAIN cycles tolerated without fifo_valid before abort
//
// Ports
//   clk        : clock, all flops on the rising edge
//   reset      : synchronous, active-high
//   start      : begin a sequence (sampled only in IDLE)
//   n_q        : Q row count; 0 ignores start, values above ROWS_MAX clamp
//   fifo_valid : core output FIFO holds a full row
//   inst       : registered core instruction word
//   busy       : sequence in progress
//   done       : one-cycle pulse at end of sequence
//   err        : sticky drain-timeout flag, cleared by accepted start/reset
// -----------------------------------------------------------------------------
module attn_seq_ctrl #(
    parameter int COL      = 8,
    parameter int ROWS_MAX = 16,
    parameter int TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  n_q,
    input  logic        fifo_valid,
    output logic [20:0] inst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [4:0] COL_LAST = 5'(COL - 1);
    localparam logic [4:0] ROWS_LIM = 5'(ROWS_MAX);
    localparam logic [6:0] TMO      = 7'(TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_KLOAD = 4'd1,
        S_QEXEC = 4'd2,
        S_DRAIN = 4'd3,
`ifdef ATTN_SEQ_SFP_NORM_EN
        S_NRD   = 4'd4,
        S_NACC  = 4'd5,
        S_NDIV  = 4'd6,
        S_NWB   = 4'd7,
`endif
        S_DONE  = 4'd8
    } state_t;

    state_t      state, state_n;
    logic [4:0]  cnt, cnt_n;
    logic [4:0]  row, row_n;
    logic [4:0]  wcnt, wcnt_n;
    logic [6:0]  tcnt, tcnt_n;
    logic [4:0]  nq, nq_n;
    logic        err_n;
    logic        wr_n;       // the cycle being entered carries a drain write
    logic [20:0] inst_n;
    logic [4:0]  nq_clamped;

    assign nq_clamped = (n_q > ROWS_LIM) ? ROWS_LIM : n_q;

    // Next-state and counter logic
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        row_n   = row;
        wcnt_n  = wcnt;
        tcnt_n  = tcnt;
        nq_n    = nq;
        err_n   = err;
        wr_n    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && (n_q != 5'd0)) begin
                    state_n = S_KLOAD;
                    nq_n    = nq_clamped;
                    cnt_n   = 5'd0;
                    row_n   = 5'd0;
                    wcnt_n  = 5'd0;
                    tcnt_n  = 7'd0;
                    err_n   = 1'b0;
                end
            end
            S_KLOAD: begin
                if (cnt == COL_LAST) begin
                    state_n = S_QEXEC;
                    cnt_n   = 5'd0;
                end else begin
                    cnt_n = cnt + 5'd1;
                end
            end
            S_QEXEC: begin
                if (cnt == nq - 5'd1) begin
                    // The first DRAIN cycle already acts on fifo_valid seen
                    // at this edge; tcnt is still 0 so no timeout is possible.
                    state_n = S_DRAIN;
                    if (fifo_valid) begin
                        wr_n   = 1'b1;
                        wcnt_n = wcnt + 5'd1;
                    end else begin
                        tcnt_n = tcnt + 7'd1;
                    end
                end else begin
                    cnt_n = cnt + 5'd1;
                end
            end
            S_DRAIN: begin
                if (wcnt == nq) begin
`ifdef ATTN_SEQ_SFP_NORM_EN
                    state_n = S_NRD;
                    row_n   = 5'd0;
`else
                    state_n = S_DONE;
`endif
                end else if (fifo_valid) begin
                    wr_n   = 1'b1;
                    wcnt_n = wcnt + 5'd1;
                    tcnt_n = 7'd0;
                end else if (tcnt == TMO) begin
                    err_n   = 1'b1;
                    state_n = S_DONE;
                end else begin
                    tcnt_n = tcnt + 7'd1;
                end
            end
`ifdef ATTN_SEQ_SFP_NORM_EN
            S_NRD:  state_n = S_NACC;
            S_NACC: state_n = S_NDIV;
            S_NDIV: state_n = S_NWB;
            S_NWB: begin
                row_n = row + 5'd1;
                if (row + 5'd1 == nq) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_NRD;
                end
            end
`endif
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Instruction word for the cycle being entered; bit 19 stays 0 always.
    always_comb begin
        inst_n = 21'd0;
        case (state_n)
            S_KLOAD: begin
                inst_n[3]     = 1'b1;          // kmem_rd
                inst_n[6]     = 1'b1;          // kernel load
                inst_n[15:12] = cnt_n[3:0];
            end
            S_QEXEC: begin
                inst_n[5]     = 1'b1;          // qmem_rd
                inst_n[7]     = 1'b1;          // execute
                inst_n[15:12] = cnt_n[3:0];
            end
            S_DRAIN: begin
                if (wr_n) begin
                    inst_n[16]   = 1'b1;       // ofifo_rd
                    inst_n[0]    = 1'b1;       // pmem_wr
                    inst_n[11:8] = wcnt[3:0];
                end
            end
`ifdef ATTN_SEQ_SFP_NORM_EN
            S_NRD: begin
                inst_n[1]    = 1'b1;           // pmem_rd
                inst_n[11:8] = row_n[3:0];
            end
            S_NACC: inst_n[18] = 1'b1;
            S_NDIV: inst_n[17] = 1'b1;
            S_NWB: begin
                inst_n[20]   = 1'b1;           // write_back
                inst_n[0]    = 1'b1;           // pmem_wr
                inst_n[11:8] = row_n[3:0];
            end
`endif
            default: inst_n = 21'd0;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 5'd0;
            row   <= 5'd0;
            wcnt  <= 5'd0;
            tcnt  <= 7'd0;
            nq    <= 5'd0;
            err   <= 1'b0;
            inst  <= 21'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            row   <= row_n;
            wcnt  <= wcnt_n;
            tcnt  <= tcnt_n;
            nq    <= nq_n;
            err   <= err_n;
            inst  <= inst_n;
            busy  <= (state_n != S_IDLE) && (state_n != S_DONE);
            done  <= (state_n == S_DONE);
        end
    end

endmodule

// File: tb/tb_attn_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_attn_seq_ctrl
//   Directed bench for attn_seq_ctrl. Expected instruction streams are built
//   from the field map per cycle and walked against the DUT output, sampled on
//   the falling edge. Normalization expectations follow ATTN_SEQ_SFP_NORM_EN.
// -----------------------------------------------------------------------------
module tb_attn_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  n_q;
    logic        fifo_valid;
    logic [20:0] inst;
    logic        busy;
    logic        done;
    logic        err;

    int nchk = 0;
    int nerr = 0;
    logic [20:0] exp_q[$];

    attn_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .n_q        (n_q),
        .fifo_valid (fifo_valid),
        .inst       (inst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected instruction words: {[20:16], [15:12], [11:8], [7], [6], [5:0]}
    function automatic logic [20:0] w_kload(int a);
        return {5'b00000, 4'(a), 4'd0, 1'b0, 1'b1, 6'b001000};
    endfunction
    function automatic logic [20:0] w_qexec(int a);
        return {5'b00000, 4'(a), 4'd0, 1'b1, 1'b0, 6'b100000};
    endfunction
    function automatic logic [20:0] w_drain(int p);
        return {5'b00001, 4'd0, 4'(p), 1'b0, 1'b0, 6'b000001};
    endfunction
    function automatic logic [20:0] w_nrd(int r);
        return {5'b00000, 4'd0, 4'(r), 1'b0, 1'b0, 6'b000010};
    endfunction
    function automatic logic [20:0] w_nacc();
        return {5'b00100, 4'd0, 4'd0, 1'b0, 1'b0, 6'b000000};
    endfunction
    function automatic logic [20:0] w_ndiv();
        return {5'b00010, 4'd0, 4'd0, 1'b0, 1'b0, 6'b000000};
    endfunction
    function automatic logic [20:0] w_nwb(int r);
        return {5'b10000, 4'd0, 4'(r), 1'b0, 1'b0, 6'b000001};
    endfunction

    task automatic push_norm(int nq);
`ifdef ATTN_SEQ_SFP_NORM_EN
        for (int r = 0; r < nq; r++) begin
            exp_q.push_back(w_nrd(r));
            exp_q.push_back(w_nacc());
            exp_q.push_back(w_ndiv());
            exp_q.push_back(w_nwb(r));
        end
`else
        if (nq < 0) exp_q.delete();
`endif
    endtask

    // Busy-cycle stream with fifo_valid held high throughout DRAIN
    task automatic build_exp(int nq);
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(w_kload(k));
        for (int k = 0; k < nq; k++) exp_q.push_back(w_qexec(k));
        for (int k = 0; k < nq; k++) exp_q.push_back(w_drain(k));
        push_norm(nq);
    endtask

    // Issue start at the next edge; returns at the falling edge of cycle T+1
    task automatic do_start(logic [4:0] nq);
        @(negedge clk);
        start = 1'b1;
        n_q   = nq;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        nchk++; if (inst !== 21'd0) begin nerr++; $display("FAIL reset_inst: got %h want 0", inst); end
        nchk++; if (busy !== 1'b0)  begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
        nchk++; if (done !== 1'b0)  begin nerr++; $display("FAIL reset_done: got %b want 0", done); end
        nchk++; if (err !== 1'b0)   begin nerr++; $display("FAIL reset_err: got %b want 0", err); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_seq();
        fifo_valid = 1'b1;
        build_exp(4);
        do_start(5'd4);
        for (int i = 0; i < exp_q.size(); i++) begin
            nchk++;
            if (inst !== exp_q[i] || busy !== 1'b1 || done !== 1'b0) begin
                nerr++;
                $display("FAIL full c%0d: inst=%h busy=%b done=%b want inst=%h busy=1 done=0",
                         i + 1, inst, busy, done, exp_q[i]);
            end
            @(negedge clk);
        end
        nchk++;
        if (done !== 1'b1 || busy !== 1'b0 || inst !== 21'd0 || err !== 1'b0) begin
            nerr++;
            $display("FAIL full_done c%0d: done=%b busy=%b inst=%h err=%b want 1 0 0 0",
                     exp_q.size() + 1, done, busy, inst, err);
        end
        @(negedge clk);
        nchk++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL full_idle: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_clamp();
        fifo_valid = 1'b1;
        build_exp(16);
        do_start(5'd20);
        for (int i = 0; i < exp_q.size(); i++) begin
            nchk++;
            if (inst !== exp_q[i] || busy !== 1'b1 || done !== 1'b0) begin
                nerr++;
                $display("FAIL clamp c%0d: inst=%h busy=%b done=%b want inst=%h busy=1 done=0",
                         i + 1, inst, busy, done, exp_q[i]);
            end
            @(negedge clk);
        end
        nchk++;
        if (done !== 1'b1 || busy !== 1'b0 || inst !== 21'd0) begin
            nerr++;
            $display("FAIL clamp_done: done=%b busy=%b inst=%h want 1 0 0", done, busy, inst);
        end
        @(negedge clk);
        // n_q = 0 must be ignored
        do_start(5'd0);
        for (int i = 0; i < 3; i++) begin
            nchk++;
            if (busy !== 1'b0 || inst !== 21'd0 || done !== 1'b0) begin
                nerr++;
                $display("FAIL nq_zero c%0d: busy=%b inst=%h done=%b want 0 0 0", i, busy, inst, done);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fifo_toggle();
        // fifo_valid seen at the edges closing cycles 10..13: 1,0,1,0
        fifo_valid = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(w_kload(k));
        exp_q.push_back(w_qexec(0));
        exp_q.push_back(w_qexec(1));
        exp_q.push_back(w_drain(0));
        exp_q.push_back(21'd0);
        exp_q.push_back(w_drain(1));
        push_norm(2);
        do_start(5'd2);
        for (int i = 0; i < exp_q.size(); i++) begin
            nchk++;
            if (inst !== exp_q[i] || busy !== 1'b1 || done !== 1'b0) begin
                nerr++;
                $display("FAIL toggle c%0d: inst=%h busy=%b done=%b want inst=%h busy=1 done=0",
                         i + 1, inst, busy, done, exp_q[i]);
            end
            fifo_valid = (i + 1 == 10) || (i + 1 == 12);
            @(negedge clk);
        end
        nchk++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            nerr++;
            $display("FAIL toggle_done: done=%b busy=%b err=%b want 1 0 0", done, busy, err);
        end
        fifo_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        fifo_valid = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(w_kload(k));
        exp_q.push_back(w_qexec(0));
        for (int k = 0; k < 64; k++) exp_q.push_back(21'd0);
        do_start(5'd1);
        for (int i = 0; i < exp_q.size(); i++) begin
            nchk++;
            if (inst !== exp_q[i] || busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
                nerr++;
                $display("FAIL timeout c%0d: inst=%h busy=%b done=%b err=%b want inst=%h 1 0 0",
                         i + 1, inst, busy, done, err, exp_q[i]);
            end
            @(negedge clk);
        end
        nchk++;
        if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL timeout_done: done=%b err=%b busy=%b want 1 1 0", done, err, busy);
        end
        repeat (3) @(negedge clk);
        nchk++;
        if (err !== 1'b1) begin nerr++; $display("FAIL err_sticky: got %b want 1", err); end
        // A new accepted start clears err and runs normally
        fifo_valid = 1'b1;
        build_exp(1);
        do_start(5'd1);
        nchk++;
        if (err !== 1'b0) begin nerr++; $display("FAIL err_clear: got %b want 0", err); end
        for (int i = 0; i < exp_q.size(); i++) begin
            nchk++;
            if (inst !== exp_q[i] || busy !== 1'b1) begin
                nerr++;
                $display("FAIL rerun c%0d: inst=%h busy=%b want inst=%h busy=1", i + 1, inst, busy, exp_q[i]);
            end
            @(negedge clk);
        end
        nchk++;
        if (done !== 1'b1 || err !== 1'b0) begin
            nerr++;
            $display("FAIL rerun_done: done=%b err=%b want 1 0", done, err);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        fifo_valid = 1'b1;
        build_exp(4);
        do_start(5'd4);
        for (int i = 0; i < exp_q.size(); i++) begin
            nchk++;
            if (inst !== exp_q[i] || busy !== 1'b1 || done !== 1'b0) begin
                nerr++;
                $display("FAIL busy_start c%0d: inst=%h busy=%b done=%b want inst=%h busy=1 done=0",
                         i + 1, inst, busy, done, exp_q[i]);
            end
            if (i == 2) begin
                start = 1'b1;
                n_q   = 5'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        nchk++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL busy_start_done: done=%b busy=%b want 1 0", done, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        fifo_valid = 1'b1;
        do_start(5'd8);
        repeat (11) @(negedge clk);   // now in cycle 12: QEXEC cnt=3
        nchk++;
        if (inst !== w_qexec(3)) begin
            nerr++;
            $display("FAIL mid_pre: inst=%h want %h", inst, w_qexec(3));
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        nchk++;
        if (inst !== 21'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            nerr++;
            $display("FAIL mid_reset: inst=%h busy=%b done=%b err=%b want 0 0 0 0", inst, busy, done, err);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            nchk++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                nerr++;
                $display("FAIL mid_after c%0d: done=%b busy=%b want 0 0", i, done, busy);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        n_q        = 5'd0;
        fifo_valid = 1'b0;
        test_reset();
        test_full_seq();
        test_clamp();
        test_fifo_toggle();
        test_timeout();
        test_start_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
